// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor: gated edge count -> rpm, speed level,
// stall flag, and a settle/monitor/fault check against fan_speed.
module fan_tach_monitor #(
   parameter int GATE_CYCLES      = 1000,
   parameter int RPM_PER_PULSE    = 30,
   parameter int SETTLE_WINDOWS   = 2,
   parameter int MISMATCH_WINDOWS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  fan_speed,
   input  logic        tach,
   output logic [11:0] rpm_meas,
   output logic [1:0]  meas_speed,
   output logic        meas_valid,
   output logic        stall,
   output logic        fault
);
   localparam int GW = $clog2(GATE_CYCLES);
   localparam int SW = $clog2(SETTLE_WINDOWS + 1);
   localparam int MW = $clog2(MISMATCH_WINDOWS + 1);

   localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_WINDOWS);
   localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
   localparam logic [MW-1:0] MISM_LAST   = MW'(MISMATCH_WINDOWS - 1);

   typedef enum logic [1:0] {
      SETTLE,
      MONITOR,
      FAULT
   } state_t;

   state_t          state;
   logic [2:0]      sync_q;
   logic [GW-1:0]   gate_cnt;
   logic [7:0]      edge_cnt;
   logic [7:0]      cnt_fin;
   logic [1:0]      cmd_q;
   logic [SW-1:0]   settle_cnt;
   logic [MW-1:0]   mism_cnt;
   logic            tach_edge;
   logic            win_end;
   logic            cmd_chg;
   logic            lvl_miss;
   logic [31:0]     rpm_raw;
   logic [11:0]     rpm_next;
   logic [1:0]      lvl_next;

   // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history
   assign tach_edge = sync_q[1] & ~sync_q[2];
   assign win_end   = (gate_cnt == GATE_LAST);
   assign cnt_fin   = (edge_cnt == 8'd255) ? 8'd255
                    : edge_cnt + {7'd0, tach_edge};
   assign rpm_raw   = 32'(cnt_fin) * 32'(RPM_PER_PULSE);
   assign rpm_next  = (rpm_raw > 32'd4095) ? 12'd4095
                    : rpm_raw[11:0];
   assign cmd_chg   = (fan_speed != cmd_q);
   assign lvl_miss  = (lvl_next != cmd_q);

   always_comb begin
      lvl_next = 2'd3;
      unique case (1'b1)
         (rpm_next < 12'd500):
            lvl_next = 2'd0;
         (rpm_next >= 12'd500 && rpm_next < 12'd1500):
            lvl_next = 2'd1;
         (rpm_next >= 12'd1500 && rpm_next < 12'd2500):
            lvl_next = 2'd2;
         default:
            lvl_next = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         rpm_meas   <= '0;
         meas_speed <= '0;
         meas_valid <= 1'b0;
         stall      <= 1'b0;
      end else begin
         sync_q     <= {sync_q[1:0], tach};
         meas_valid <= win_end;
         if (win_end) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            rpm_meas   <= rpm_next;
            meas_speed <= lvl_next;
            stall      <= (cnt_fin == 8'd0);
         end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= cnt_fin;
         end
      end
   end

   // a command change wins over a coincident window result
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q      <= fan_speed;
         state      <= SETTLE;
         settle_cnt <= SETTLE_INIT;
         mism_cnt   <= '0;
         fault      <= 1'b0;
      end else begin
         cmd_q <= fan_speed;
         if (cmd_chg) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_INIT;
            mism_cnt   <= '0;
            fault      <= 1'b0;
         end else if (win_end) begin
            unique case (state)
               SETTLE: begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (settle_cnt == SETTLE_ONE)
                     state <= MONITOR;
               end
               MONITOR: begin
                  if (!lvl_miss) begin
                     mism_cnt <= '0;
                  end else if (mism_cnt == MISM_LAST) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     mism_cnt <= mism_cnt + 1'b1;
                  end
               end
               FAULT: begin
                  if (!lvl_miss) begin
                     state    <= MONITOR;
                     fault    <= 1'b0;
                     mism_cnt <= '0;
                  end
               end
               default: state <= SETTLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Bench for fan_tach_monitor: window-level reference model plus
// directed scenarios and randomized tach/command stimulus.
module tb_fan_tach_monitor;
   localparam int G    = 1000;
   localparam int RPM  = 30;
   localparam int SWIN = 2;
   localparam int MWIN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  fan_speed = 2'd0;
   logic        tach = 1'b0;
   logic [11:0] rpm_meas;
   logic [1:0]  meas_speed;
   logic        meas_valid;
   logic        stall;
   logic        fault;

   int n_cmp = 0;
   int n_bad = 0;

   fan_tach_monitor #(
      .GATE_CYCLES(G),
      .RPM_PER_PULSE(RPM),
      .SETTLE_WINDOWS(SWIN),
      .MISMATCH_WINDOWS(MWIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fan_speed(fan_speed),
      .tach(tach),
      .rpm_meas(rpm_meas),
      .meas_speed(meas_speed),
      .meas_valid(meas_valid),
      .stall(stall),
      .fault(fault)
   );

   always #5 clk = ~clk;

   // reference model state
   int          cyc;
   bit          prev_t;
   int          rises[int];
   logic [1:0]  cmd;
   int          settle_left;
   int          streak;
   logic [11:0] e_rpm;
   logic [1:0]  e_spd;
   logic        e_valid;
   logic        e_stall;
   logic        e_fault;

   function automatic logic [1:0] level_of(input int r);
      if (r < 500)  return 2'd0;
      if (r < 1500) return 2'd1;
      if (r < 2500) return 2'd2;
      return 2'd3;
   endfunction

   // Rises seen on tach are attributed to the window two cycles later,
   // the synchronizer delay; each window end publishes its total.
   task automatic model_step();
      int w;
      int c;
      int r;
      bit we;
      logic [1:0] lv;
      lv = 2'd0;
      if (rst) begin
         cyc = 0;
         prev_t = 1'b0;
         rises.delete();
         cmd = fan_speed;
         settle_left = SWIN;
         streak = 0;
         e_rpm = '0;
         e_spd = '0;
         e_valid = 1'b0;
         e_stall = 1'b0;
         e_fault = 1'b0;
      end else begin
         if (tach && !prev_t) begin
            w = (cyc + 2) / G;
            if (rises.exists(w)) rises[w] = rises[w] + 1;
            else rises[w] = 1;
         end
         prev_t = tach;
         we = ((cyc % G) == G - 1);
         e_valid = we;
         if (we) begin
            w = cyc / G;
            c = rises.exists(w) ? rises[w] : 0;
            if (c > 255) c = 255;
            r = c * RPM;
            if (r > 4095) r = 4095;
            lv = level_of(r);
            e_rpm = 12'(r);
            e_spd = lv;
            e_stall = (c == 0);
            rises.delete(w);
         end
         if (fan_speed != cmd) begin
            settle_left = SWIN;
            streak = 0;
         end else if (we) begin
            if (settle_left > 0) settle_left = settle_left - 1;
            else if (lv != cmd) streak = streak + 1;
            else streak = 0;
         end
         e_fault = (streak >= MWIN);
         cmd = fan_speed;
         cyc = cyc + 1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // per-cycle comparison of every output against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         n_cmp = n_cmp + 1;
         if ({rpm_meas, meas_speed, meas_valid, stall, fault} !==
             {e_rpm, e_spd, e_valid, e_stall, e_fault}) begin
            n_bad = n_bad + 1;
            $display("FAIL cycle_cmp t=%0t dut rpm=%0d spd=%0d v=%b st=%b f=%b req rpm=%0d spd=%0d v=%b st=%b f=%b",
                     $time, rpm_meas, meas_speed, meas_valid, stall,
                     fault, e_rpm, e_spd, e_valid, e_stall, e_fault);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one full window of evenly spaced pulses, optional command change
   task automatic run_window(input int npulse, input int chg_at = -1,
                             input logic [1:0] new_spd = 2'd0);
      int per;
      per = (npulse > 0) ? G / npulse : G;
      for (int c = 0; c < G; c++) begin
         tach = (npulse > 0) && (c / per < npulse) &&
                (c % per < per / 2);
         if (c == chg_at) begin
            check("fault_before_chg", 32'(fault), 32'd1);
            fan_speed = new_spd;
         end
         tick();
         if (c == chg_at)
            check("fault_after_chg", 32'(fault), 32'd0);
      end
   endtask

   task automatic check_win(input string nm, input int r,
                            input int s, input int f);
      check({nm, "_valid"}, 32'(meas_valid), 32'd1);
      check({nm, "_rpm"}, 32'(rpm_meas), 32'(r));
      check({nm, "_spd"}, 32'(meas_speed), 32'(s));
      check({nm, "_fault"}, 32'(fault), 32'(f));
   endtask

   initial begin
      int dens;
      rst = 1'b1;
      fan_speed = 2'd2;
      tach = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_outputs",
               {15'd0, rpm_meas, meas_speed, meas_valid, stall, fault},
               32'd0);
      end
      rst = 1'b0;

      run_window(67);
      check_win("w67", 2010, 2, 0);
      check("w67_stall", 32'(stall), 32'd0);
      check("model_pin_2010", 32'(e_rpm), 32'd2010);

      run_window(0);
      check_win("w0", 0, 0, 0);
      check("w0_stall", 32'(stall), 32'd1);

      run_window(200);
      check_win("w200", 4095, 3, 0);
      check("model_pin_4095", 32'(e_rpm), 32'd4095);

      // reset in the middle of a busy window
      for (int c = 0; c < 437; c++) begin
         tach = (c % 7) < 3;
         tick();
      end
      tach = 1'b0;
      rst = 1'b1;
      fan_speed = 2'd3;
      repeat (3) tick();
      check("rst_mid_rpm", 32'(rpm_meas), 32'd0);
      rst = 1'b0;

      for (int i = 1; i <= 4; i++) begin
         run_window(34);
         check_win("w34_pre", 1020, 1, 0);
      end
      run_window(34);
      check_win("w34_fault", 1020, 1, 1);
      check("model_pin_fault", 32'(e_fault), 32'd1);
      run_window(100);
      check_win("w100_clear", 3000, 3, 0);

      for (int i = 0; i < 3; i++) run_window(34);
      check_win("refault", 1020, 1, 1);

      // command change mid-window while faulted
      run_window(34, 500, 2'd1);
      check_win("chg_settle1", 1020, 1, 0);
      run_window(100);
      check_win("chg_settle2", 3000, 3, 0);
      run_window(100);
      check_win("chg_mon1", 3000, 3, 0);
      run_window(100);
      check_win("chg_mon2", 3000, 3, 0);
      run_window(100);
      check_win("chg_mon3", 3000, 3, 1);

      // command change on the window-end cycle
      run_window(100, G - 1, 2'd2);
      check_win("edge_chg", 3000, 3, 0);
      run_window(100);
      check_win("edge_settle", 3000, 3, 0);

      // randomized tach density, command changes and one reset
      for (int w = 0; w < 8; w++) begin
         dens = int'($urandom_range(1, 40));
         for (int c = 0; c < G; c++) begin
            if ($urandom_range(0, dens) == 0) tach = ~tach;
            if ($urandom_range(0, 1499) == 0)
               fan_speed = 2'($urandom_range(0, 3));
            rst = (w == 5) && (c >= 300) && (c < 302);
            tick();
         end
      end
      rst = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
